btn_debouncer: RTL

- Input-conditioning stage directly upstream of the LED control top.
- Takes the raw, asynchronous push-button vector from the board pins.
- For each button: synchronises it, debounces it with a per-button stability counter, and produces a clean level plus one-cycle press/release pulses.
- The LED mode/colour logic consumes the pulses instead of raw buttons.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_debounce_ch.sv | 103 ++++++++++
 rtl/btn_debouncer.sv | 39 +++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared button constants: channel count, debounce lengths, button roles and channel state type.
// Index constants are shared with the LED control logic.
package btn_pkg;

  localparam int N_BTN = 4;

  // 20 ms at 100 MHz. The terminal count is 1_999_999, so a synthesis build
  // using this value needs CNT_W of at least 21.
  localparam int DEBOUNCE_CYCLES_SYNTH = 2_000_000;
  localparam int DEBOUNCE_CYCLES_SIM   = 16;
  localparam int CNT_W_DEFAULT         = 20;

  localparam int BTN_FLASH = 0;
  localparam int BTN_SHIFT = 2;
  localparam int BTN_COLOR = 3;

  typedef enum logic {
    CH_STABLE   = 1'b0,
    CH_COUNTING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, stability counter, debounced level and press/release pulses.
// With BTN_TOGGLE_EN defined, also a toggle bit that flips on the edge after each press pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic i_ck_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press,
  output logic o_release,
`ifdef BTN_TOGGLE_EN
  output logic o_toggle,
`endif
  output logic o_counting
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1, s2;
  ch_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, press_n, release_n;

  always_ff @(posedge clock or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      state     <= CH_STABLE;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      o_level   <= level_n;
      o_press   <= press_n;
      o_release <= release_n;
    end
  end

  // The counter only runs while s2 disagrees with the level; any agreement restarts it.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = o_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      CH_STABLE: begin
        cnt_n = '0;
        if (s2 != o_level) begin
          state_n = CH_COUNTING;
          cnt_n   = CNT_ONE;
        end
      end
      CH_COUNTING: begin
        if (s2 == o_level) begin
          state_n = CH_STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = CH_STABLE;
          cnt_n     = '0;
          level_n   = s2;
          press_n   = s2;
          release_n = ~s2;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = CH_STABLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign o_counting = (state == CH_COUNTING);

`ifdef BTN_TOGGLE_EN
  always_ff @(posedge clock or negedge i_ck_reset) begin
    if (!i_ck_reset) begin
      o_toggle <= 1'b0;
    end else begin
      o_toggle <= o_toggle ^ o_press;
    end
  end
`endif

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioning: N_BTN independent debounce channels producing level and press/release pulses.
// Define BTN_TOGGLE_EN to add o_btn_toggle, one latched bit per button flipped by each press.
module btn_debouncer #(
  parameter int N_BTN           = btn_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES_SIM,
  parameter int CNT_W           = btn_pkg::CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             i_ck_reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
`ifdef BTN_TOGGLE_EN
  output logic [N_BTN-1:0] o_btn_toggle,
`endif
  // Per-channel debug view of the channel FSM: 1 while counting toward a level change.
  output logic [N_BTN-1:0] o_dbg_state
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clock     (clock),
      .i_ck_reset(i_ck_reset),
      .i_btn     (i_btn[i]),
      .o_level   (o_btn_level[i]),
      .o_press   (o_btn_press[i]),
      .o_release (o_btn_release[i]),
`ifdef BTN_TOGGLE_EN
      .o_toggle  (o_btn_toggle[i]),
`endif
      .o_counting(o_dbg_state[i])
    );
  end

endmodule
